// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Turns the UART receive byte stream into queued I2C operation requests.
// Accepted tokens: S (START), P (STOP), R (READ+ACK), N (READ+NAK), and
// two hex digits (WRITE of that byte). Whitespace separates tokens but is
// not required. The block also tracks XON/XOFF to gate the UART transmitter.
// It never back-pressures the receiver: a push into a full queue is dropped
// and reported as an overflow error.
module uart_cmd_parser #(
  parameter int CMD_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  input  logic                         rx_frame_err,
  output logic                         tx_enable,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [1:0]                   cmd_op,
  output logic [7:0]                   cmd_data,
  output logic                         cmd_nak,
  output logic [$clog2(CMD_DEPTH):0]   cmd_count,
  output logic                         err_pulse,
  output logic [1:0]                   err_code
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam logic [AW:0] FULL_CNT = CMD_DEPTH[AW:0];

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;

  localparam logic [1:0] ERR_CHAR  = 2'd0;
  localparam logic [1:0] ERR_HEX   = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_FRAME = 2'd3;

  localparam logic [7:0] CH_XON  = 8'h11;
  localparam logic [7:0] CH_XOFF = 8'h13;
  localparam logic [7:0] CH_CR   = 8'h0d;
  localparam logic [7:0] CH_LF   = 8'h0a;
  localparam logic [7:0] CH_SP   = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEX1 = 2'd1,
    ST_SKIP = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
    logic       nak;
  } cmd_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_nib;
  logic        r_tx_en;
  logic        r_err_pulse;
  logic [1:0]  r_err_code;

  cmd_t        r_mem [CMD_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic        w_byte;
  logic        w_frame;
  logic        w_parse;
  logic        w_is_hex;
  logic [3:0]  w_hex_val;
  logic        w_is_ws;
  logic        w_is_cmd;
  logic        w_push;
  cmd_t        w_push_ent;
  logic        w_perr;
  logic [1:0]  w_perr_code;
  logic        w_full;
  logic        w_pop;
  logic        w_wr;
  logic        w_ovf;
  logic        w_err;
  logic [1:0]  w_err_code;
  cmd_t        w_head;

  // Byte qualification: a framing error hides the byte from flow control and parser.
  assign w_byte  = rx_valid & ~rx_frame_err;
  assign w_frame = rx_valid & rx_frame_err;
  assign w_parse = w_byte & (rx_data != CH_XON) & (rx_data != CH_XOFF);

  // Character classification of the incoming byte.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_is_hex  = 1'b0;
    w_hex_val = rx_data[3:0];
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      w_is_hex = 1'b1;
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
      w_is_hex  = 1'b1;
      w_hex_val = rx_data[3:0] + 4'd9;
    end
  end

  assign w_is_ws  = (rx_data == CH_SP) | (rx_data == CH_CR) | (rx_data == CH_LF);
  assign w_is_cmd = (rx_data == 8'h53) | (rx_data == 8'h50) |
                    (rx_data == 8'h52) | (rx_data == 8'h4e);

  // Parser state register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Parser next-state: one transition per qualified, non-flow-control byte.
  always_comb begin
    w_state_nxt = r_state;
    if (w_frame) begin
      w_state_nxt = ST_SKIP;
    end else if (w_parse) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_hex)                 w_state_nxt = ST_HEX1;
          else if (w_is_cmd || w_is_ws) w_state_nxt = ST_IDLE;
          else                          w_state_nxt = ST_SKIP;
        end
        ST_HEX1: begin
          if (w_is_hex || w_is_ws) w_state_nxt = ST_IDLE;
          else                     w_state_nxt = ST_SKIP;
        end
        ST_SKIP: begin
          if (rx_data == CH_CR) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Parser outputs: queue push request and parse errors for the current byte.
  always_comb begin
    w_push      = 1'b0;
    w_push_ent  = '0;
    w_perr      = 1'b0;
    w_perr_code = ERR_CHAR;
    if (w_parse) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == 8'h53) begin
            w_push        = 1'b1;
            w_push_ent.op = OP_START;
          end else if (rx_data == 8'h50) begin
            w_push        = 1'b1;
            w_push_ent.op = OP_STOP;
          end else if (rx_data == 8'h52 || rx_data == 8'h4e) begin
            w_push         = 1'b1;
            w_push_ent.op  = OP_READ;
            w_push_ent.nak = (rx_data == 8'h4e);
          end else if (!w_is_hex && !w_is_ws) begin
            w_perr      = 1'b1;
            w_perr_code = ERR_CHAR;
          end
        end
        ST_HEX1: begin
          if (w_is_hex) begin
            w_push          = 1'b1;
            w_push_ent.op   = OP_WRITE;
            w_push_ent.data = {r_nib, w_hex_val};
          end else begin
            w_perr      = 1'b1;
            w_perr_code = w_is_ws ? ERR_HEX : ERR_CHAR;
          end
        end
        default: ;
      endcase
    end
  end

  // High-nibble holding register, loaded on the first digit of a hex pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   r_nib <= 4'd0;
    else if (w_parse && r_state == ST_IDLE && w_is_hex) r_nib <= w_hex_val;
  end

  // XON/XOFF tracking: XOFF disables the transmitter, any other good byte re-enables it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_tx_en <= 1'b1;
    else if (w_byte) r_tx_en <= (rx_data != CH_XOFF);
  end

  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = cmd_valid & cmd_ready;
  assign w_wr   = w_push & (~w_full | w_pop);
  assign w_ovf  = w_push & w_full & ~w_pop;

  // Command queue storage and pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: storage is reset because the head drives cmd_* directly and must read zero out of reset.
      for (int i = 0; i < CMD_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_push_ent;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Queue occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_err      = w_frame | w_perr | w_ovf;
  assign w_err_code = w_frame ? ERR_FRAME : (w_perr ? w_perr_code : ERR_OVF);

  // Error strobe and sticky error code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_pulse <= 1'b0;
      r_err_code  <= ERR_CHAR;
    end else begin
      r_err_pulse <= w_err;
      if (w_err) r_err_code <= w_err_code;
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign cmd_op    = w_head.op;
  assign cmd_data  = w_head.data;
  assign cmd_nak   = w_head.nak;
  assign cmd_valid = (r_count != '0);
  assign cmd_count = r_count;
  assign tx_enable = r_tx_en;
  assign err_pulse = r_err_pulse;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: directed scenarios plus random byte
// streams, all scored against a token-level reference model.
module tb_uart_cmd_parser;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_frame_err;
  logic          tx_enable;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [7:0]    cmd_data;
  logic          cmd_nak;
  logic [CW-1:0] cmd_count;
  logic          err_pulse;
  logic [1:0]    err_code;

  uart_cmd_parser #(.CMD_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .tx_enable    (tx_enable),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_nak      (cmd_nak),
    .cmd_count    (cmd_count),
    .err_pulse    (err_pulse),
    .err_code     (err_code)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] data;
    logic       nak;
  } ent_t;

  // Reference model: expected queue contents plus token-level parser context.
  ent_t       mq[$];
  int         hi_nib;     // pending high nibble of a hex pair, -1 when none
  bit         skipping;   // discarding bytes until CR
  logic       exp_tx;
  logic       exp_pulse;
  logic [1:0] exp_code;

  int total = 0;
  int bad   = 0;

  function automatic int hexval(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
    if (b >= 8'h41 && b <= 8'h46) return int'(b) - 55;
    if (b >= 8'h61 && b <= 8'h66) return int'(b) - 87;
    return -1;
  endfunction

  function automatic bit is_ws(input logic [7:0] b);
    return (b == 8'h20) || (b == 8'h0d) || (b == 8'h0a);
  endfunction

  function automatic ent_t mk(input int op, input int data, input bit nak);
    ent_t e;
    e.op   = 2'(op);
    e.data = 8'(data);
    e.nak  = nak;
    return e;
  endfunction

  task automatic model_reset();
    mq.delete();
    hi_nib    = -1;
    skipping  = 1'b0;
    exp_tx    = 1'b1;
    exp_pulse = 1'b0;
    exp_code  = 2'd0;
  endtask

  // One clock cycle, entered and left at a falling edge: score the outputs
  // settled by the previous edge, drive this cycle's inputs, advance the model.
  task automatic step(input bit v, input logic [7:0] b, input bit fe, input bit rdy);
    bit   has_push;
    ent_t e;
    int   err;
    int   sz;
    bit   pop;
    total++;
    if (cmd_count !== CW'(mq.size())) begin
      bad++; $display("FAIL cmd_count: got %0d want %0d", cmd_count, mq.size());
    end
    total++;
    if (cmd_valid !== (mq.size() != 0)) begin
      bad++; $display("FAIL cmd_valid: got %0b want %0b", cmd_valid, mq.size() != 0);
    end
    if (mq.size() != 0) begin
      total++;
      if ({cmd_op, cmd_data, cmd_nak} !== mq[0]) begin
        bad++;
        $display("FAIL head: got op=%0d data=%02h nak=%0b want op=%0d data=%02h nak=%0b",
                 cmd_op, cmd_data, cmd_nak, mq[0].op, mq[0].data, mq[0].nak);
      end
    end
    total++;
    if (tx_enable !== exp_tx) begin
      bad++; $display("FAIL tx_enable: got %0b want %0b", tx_enable, exp_tx);
    end
    total++;
    if (err_pulse !== exp_pulse) begin
      bad++; $display("FAIL err_pulse: got %0b want %0b", err_pulse, exp_pulse);
    end
    total++;
    if (err_code !== exp_code) begin
      bad++; $display("FAIL err_code: got %0d want %0d", err_code, exp_code);
    end

    rx_valid     = v;
    rx_data      = b;
    rx_frame_err = fe;
    cmd_ready    = rdy;

    has_push = 1'b0;
    e        = '0;
    err      = -1;
    if (v && fe) begin
      err      = 3;
      skipping = 1'b1;
      hi_nib   = -1;
    end else if (v) begin
      exp_tx = (b != 8'h13);
      if (b == 8'h11 || b == 8'h13) begin
        // flow-control characters never reach the parser
      end else if (skipping) begin
        if (b == 8'h0d) skipping = 1'b0;
      end else if (hi_nib >= 0) begin
        if (hexval(b) >= 0) begin
          has_push = 1'b1;
          e        = mk(2, hi_nib * 16 + hexval(b), 1'b0);
        end else if (is_ws(b)) begin
          err = 1;
        end else begin
          err      = 0;
          skipping = 1'b1;
        end
        hi_nib = -1;
      end else if (b == 8'h53) begin
        has_push = 1'b1; e = mk(0, 0, 1'b0);
      end else if (b == 8'h50) begin
        has_push = 1'b1; e = mk(1, 0, 1'b0);
      end else if (b == 8'h52) begin
        has_push = 1'b1; e = mk(3, 0, 1'b0);
      end else if (b == 8'h4e) begin
        has_push = 1'b1; e = mk(3, 0, 1'b1);
      end else if (hexval(b) >= 0) begin
        hi_nib = hexval(b);
      end else if (!is_ws(b)) begin
        err      = 0;
        skipping = 1'b1;
      end
    end

    sz  = mq.size();
    pop = rdy && (sz > 0);
    if (pop) void'(mq.pop_front());
    if (has_push) begin
      if (sz == DEPTH && !pop) err = 2;
      else                     mq.push_back(e);
    end
    exp_pulse = (err >= 0);
    if (err >= 0) exp_code = 2'(err);

    @(negedge clk);
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
  endtask

  task automatic send_str(input string s, input bit rdy);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
    rx_data      = 8'h00;
    cmd_ready    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({tx_enable, cmd_valid, cmd_count, cmd_op, cmd_data, cmd_nak, err_pulse, err_code} !==
        {1'b1, 1'b0, CW'(0), 2'd0, 8'h00, 1'b0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL reset_values: tx=%0b valid=%0b count=%0d op=%0d data=%02h nak=%0b pulse=%0b code=%0d",
               tx_enable, cmd_valid, cmd_count, cmd_op, cmd_data, cmd_nak, err_pulse, err_code);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    send_str("S A5 P\015", 1'b0);
    total++;
    if (cmd_count !== CW'(3)) begin
      bad++; $display("FAIL basic_peak: got count %0d want 3", cmd_count);
    end
    total++;
    if (err_code !== 2'd0) begin
      bad++; $display("FAIL basic_noerr: got err_code %0d want 0", err_code);
    end
    drain();
  endtask

  task automatic test_char_err();
    send_str("S 5x", 1'b0);
    total++;
    if (err_pulse !== 1'b1 || err_code !== 2'd0) begin
      bad++; $display("FAIL char_err: got pulse=%0b code=%0d want pulse=1 code=0", err_pulse, err_code);
    end
    send_str("S9\015", 1'b0);
    send_str("50\015", 1'b0);
    total++;
    if (cmd_count !== CW'(2)) begin
      bad++; $display("FAIL char_skip: got count %0d want 2", cmd_count);
    end
    drain();
  endtask

  task automatic test_hex_err();
    send_str("7 ", 1'b0);
    total++;
    if (err_pulse !== 1'b1 || err_code !== 2'd1 || cmd_count !== CW'(0)) begin
      bad++; $display("FAIL hex_err: got pulse=%0b code=%0d count=%0d want 1/1/0",
                      err_pulse, err_code, cmd_count);
    end
    send_str("R", 1'b0);
    drain();
  endtask

  task automatic test_overflow();
    send_str("RRRR", 1'b0);
    total++;
    if (cmd_count !== CW'(DEPTH)) begin
      bad++; $display("FAIL ovf_full: got count %0d want %0d", cmd_count, DEPTH);
    end
    send_str("N", 1'b0);
    total++;
    if (err_pulse !== 1'b1 || err_code !== 2'd2 || cmd_count !== CW'(DEPTH)) begin
      bad++; $display("FAIL ovf_err: got pulse=%0b code=%0d count=%0d want 1/2/%0d",
                      err_pulse, err_code, cmd_count, DEPTH);
    end
    send_str("S", 1'b1);
    total++;
    if (err_pulse !== 1'b0 || cmd_count !== CW'(DEPTH)) begin
      bad++; $display("FAIL ovf_pushpop: got pulse=%0b count=%0d want 0/%0d",
                      err_pulse, cmd_count, DEPTH);
    end
    drain();
  endtask

  task automatic test_flow();
    send_str("P", 1'b0);
    step(1'b1, 8'h13, 1'b0, 1'b0);
    total++;
    if (tx_enable !== 1'b0 || cmd_count !== CW'(1)) begin
      bad++; $display("FAIL xoff: got tx=%0b count=%0d want 0/1", tx_enable, cmd_count);
    end
    step(1'b1, 8'h41, 1'b0, 1'b0);
    total++;
    if (tx_enable !== 1'b1) begin
      bad++; $display("FAIL xon_any: got tx=%0b want 1", tx_enable);
    end
    step(1'b1, 8'h11, 1'b0, 1'b0);
    send_str("5", 1'b0);
    drain();
  endtask

  task automatic test_frame_and_reset();
    step(1'b1, 8'h53, 1'b1, 1'b0);
    total++;
    if (err_pulse !== 1'b1 || err_code !== 2'd3 || cmd_count !== CW'(0)) begin
      bad++; $display("FAIL frame: got pulse=%0b code=%0d count=%0d want 1/3/0",
                      err_pulse, err_code, cmd_count);
    end
    send_str("\015SR", 1'b0);
    step(1'b1, 8'h13, 1'b0, 1'b0);
    send_str("5", 1'b0);
    reset = 1'b0;
    #1;
    total++;
    if ({tx_enable, cmd_valid, cmd_count, cmd_op, cmd_data, cmd_nak, err_pulse, err_code} !==
        {1'b1, 1'b0, CW'(0), 2'd0, 8'h00, 1'b0, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL midline_reset: tx=%0b valid=%0b count=%0d op=%0d data=%02h nak=%0b pulse=%0b code=%0d",
               tx_enable, cmd_valid, cmd_count, cmd_op, cmd_data, cmd_nak, err_pulse, err_code);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_str("P", 1'b0);
    drain();
  endtask

  task automatic test_random();
    string alphabet = "SPRN0123456789abcdefABCDEFxZs \015\012";
    logic [7:0] b;
    for (int i = 0; i < 600; i++) begin
      int r = $urandom_range(0, 99);
      bit v   = (r < 70);
      bit fe  = v && ($urandom_range(0, 24) == 0);
      bit rdy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) b = ($urandom_range(0, 1) != 0) ? 8'h13 : 8'h11;
      else                            b = alphabet[$urandom_range(0, alphabet.len() - 1)];
      step(v, b, fe, rdy);
    end
    send_str("\015", 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_char_err();
    test_hex_err();
    test_overflow();
    test_flow();
    test_frame_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
